// File: rtl/elevator_ctrl_scan.sv
// SCAN elevator controller: latches floor calls, sweeps in one direction
// before reversing, times travel per floor and door dwell internally.
module elevator_ctrl_scan #(
    parameter int FLOORS     = 8,
    parameter int TRAVEL_CYC = 4,
    parameter int DOOR_CYC   = 6,
    localparam int FW        = $clog2(FLOORS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLOORS-1:0] req,
    input  logic              inopen,
    input  logic              inclose,
    output logic              up,
    output logic              down,
    output logic              open,
    output logic              close,
    output logic [FW-1:0]     floor,
    output logic [FLOORS-1:0] pending,
    output logic              idle
);

    localparam int TW = (TRAVEL_CYC > 1) ? $clog2(TRAVEL_CYC) : 1;
    localparam int DW = (DOOR_CYC > 1) ? $clog2(DOOR_CYC) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TRAVEL_CYC - 1);
    localparam logic [DW-1:0] DLAST = DW'(DOOR_CYC - 1);
    localparam logic [FW-1:0] FTOP  = FW'(FLOORS - 1);
    localparam logic          DIR_UP = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MOVE,
        S_OPEN
    } state_t;

    state_t            state_q, state_d;
    logic              dir_q, dir_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;
    logic [DW-1:0]     dcnt_q, dcnt_d;
    logic [FW-1:0]     floor_q, floor_d;
    logic [FLOORS-1:0] pending_q, pending_d;
    logic              up_q, up_d;
    logic              down_q, down_d;
    logic              open_q, open_d;
    logic              close_q, close_d;
    logic              idle_q, idle_d;

    logic              ahead, behind, beyond;
    logic [FW-1:0]     nfloor;

    function automatic logic any_above(input logic [FLOORS-1:0] p,
                                       input logic [FW-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (i > int'(f) && p[i]) r = 1'b1;
        end
        return r;
    endfunction

    function automatic logic any_below(input logic [FLOORS-1:0] p,
                                       input logic [FW-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (i < int'(f) && p[i]) r = 1'b1;
        end
        return r;
    endfunction

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        floor_d   = floor_q;
        tcnt_d    = '0;
        dcnt_d    = '0;
        pending_d = pending_q | req;

        if (dir_q == DIR_UP) begin
            ahead  = any_above(pending_q, floor_q);
            behind = any_below(pending_q, floor_q);
            nfloor = (floor_q == FTOP) ? floor_q : floor_q + 1'b1;
            beyond = any_above(pending_q, nfloor);
        end else begin
            ahead  = any_below(pending_q, floor_q);
            behind = any_above(pending_q, floor_q);
            nfloor = (floor_q == '0) ? floor_q : floor_q - 1'b1;
            beyond = any_below(pending_q, nfloor);
        end

        case (state_q)
            S_IDLE: begin
                if (pending_q[floor_q] || inopen) begin
                    state_d = S_OPEN;
                end else if (ahead) begin
                    state_d = S_MOVE;
                end else if (behind) begin
                    state_d = S_MOVE;
                    dir_d   = ~dir_q;
                end
            end
            S_MOVE: begin
                if (tcnt_q == TLAST) begin
                    floor_d = nfloor;
                    if (pending_q[nfloor]) begin
                        state_d = S_OPEN;
                    end else if (!beyond) begin
                        state_d = S_IDLE;
                    end
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            S_OPEN: begin
                // a fresh call for this landing holds the door like inopen
                if (inopen || req[floor_q]) begin
                    dcnt_d = '0;
                end else if (inclose || dcnt_q == DLAST) begin
                    state_d = S_IDLE;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_OPEN) pending_d[floor_d] = 1'b0;

        up_d    = (state_d == S_MOVE) && (dir_d == DIR_UP);
        down_d  = (state_d == S_MOVE) && (dir_d != DIR_UP);
        open_d  = (state_d == S_OPEN);
        close_d = (state_d != S_OPEN);
        idle_d  = (state_d == S_IDLE) && (pending_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            dir_q     <= DIR_UP;
            tcnt_q    <= '0;
            dcnt_q    <= '0;
            floor_q   <= '0;
            pending_q <= '0;
            up_q      <= 1'b0;
            down_q    <= 1'b0;
            open_q    <= 1'b0;
            close_q   <= 1'b1;
            idle_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            tcnt_q    <= tcnt_d;
            dcnt_q    <= dcnt_d;
            floor_q   <= floor_d;
            pending_q <= pending_d;
            up_q      <= up_d;
            down_q    <= down_d;
            open_q    <= open_d;
            close_q   <= close_d;
            idle_q    <= idle_d;
        end
    end

    assign up      = up_q;
    assign down    = down_q;
    assign open    = open_q;
    assign close   = close_q;
    assign floor   = floor_q;
    assign pending = pending_q;
    assign idle    = idle_q;

endmodule

// File: tb/tb_elevator_ctrl_scan.sv
// Directed bench for elevator_ctrl_scan: 8-floor default car plus a
// 4-floor instance, hand-computed cycle-accurate expectations.
module tb_elevator_ctrl_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       inopen, inclose;
    logic       up, down, dopen, dclose, idle;
    logic [2:0] floor;
    logic [7:0] pending;

    logic [3:0] req4;
    logic       inopen4, inclose4;
    logic       up4, down4, dopen4, dclose4, idle4;
    logic [1:0] floor4;
    logic [3:0] pending4;

    int total, bad;
    int cyc;
    int upcnt, dncnt, opencnt, upcnt4, maxf4;

    always #5 clk = ~clk;

    elevator_ctrl_scan u8 (
        .clk(clk), .rst(rst), .req(req),
        .inopen(inopen), .inclose(inclose),
        .up(up), .down(down), .open(dopen), .close(dclose),
        .floor(floor), .pending(pending), .idle(idle)
    );

    elevator_ctrl_scan #(.FLOORS(4)) u4 (
        .clk(clk), .rst(rst), .req(req4),
        .inopen(inopen4), .inclose(inclose4),
        .up(up4), .down(down4), .open(dopen4), .close(dclose4),
        .floor(floor4), .pending(pending4), .idle(idle4)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        upcnt   += int'(up);
        dncnt   += int'(down);
        opencnt += int'(dopen);
        upcnt4  += int'(up4);
        if (int'(floor4) > maxf4) maxf4 = int'(floor4);
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        req4 = '0;
        inopen = 1'b0;
        inclose = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        upcnt = 0;
        dncnt = 0;
        opencnt = 0;
        upcnt4 = 0;
        maxf4 = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad = 0;
        inopen4 = 1'b0;
        inclose4 = 1'b0;

        // reset values
        do_reset();
        chk("rst_up", up, 0);
        chk("rst_down", down, 0);
        chk("rst_open", dopen, 0);
        chk("rst_close", dclose, 1);
        chk("rst_floor", floor, 0);
        chk("rst_pend", pending, 0);
        chk("rst_idle", idle, 1);
        chk("rst4_close", dclose4, 1);

        // single trip 0 -> 5
        req = 8'h20;
        step();
        req = '0;
        chk("trip_pend1", pending, 8'h20);
        step();
        chk("trip_up2", up, 1);
        run_to(21);
        chk("trip_f21", floor, 4);
        chk("trip_up21", up, 1);
        step();
        chk("trip_f22", floor, 5);
        chk("trip_open22", dopen, 1);
        chk("trip_pend22", pending, 0);
        chk("trip_up22", up, 0);
        run_to(27);
        chk("trip_open27", dopen, 1);
        step();
        chk("trip_open28", dopen, 0);
        chk("trip_close28", dclose, 1);
        chk("trip_idle28", idle, 1);
        chk("trip_upcnt", upcnt, 20);

        // SCAN ordering: heading to 6, calls at 1 and 5 placed at floor 3
        do_reset();
        req = 8'h40;
        step();
        req = '0;
        run_to(14);
        chk("scan_f14", floor, 3);
        chk("scan_up14", up, 1);
        req = 8'h22;
        step();
        req = '0;
        chk("scan_pend15", pending, 8'h62);
        run_to(22);
        chk("scan_f22", floor, 5);
        chk("scan_open22", dopen, 1);
        chk("scan_pend22", pending, 8'h42);
        run_to(27);
        chk("scan_open27", dopen, 1);
        step();
        chk("scan_open28", dopen, 0);
        run_to(33);
        chk("scan_f33", floor, 6);
        chk("scan_open33", dopen, 1);
        chk("scan_pend33", pending, 8'h02);
        run_to(38);
        chk("scan_open38", dopen, 1);
        step();
        chk("scan_open39", dopen, 0);
        chk("scan_nodown", dncnt, 0);
        step();
        chk("scan_down40", down, 1);
        run_to(59);
        chk("scan_f59", floor, 2);
        chk("scan_down59", down, 1);
        step();
        chk("scan_f60", floor, 1);
        chk("scan_open60", dopen, 1);
        chk("scan_pend60", pending, 0);
        chk("scan_down60", down, 0);
        chk("scan_dncnt", dncnt, 20);

        // door buttons at floor 2
        do_reset();
        req = 8'h04;
        step();
        req = '0;
        run_to(10);
        chk("door_f10", floor, 2);
        chk("door_open10", dopen, 1);
        inopen = 1'b1;
        run_to(20);
        inopen = 1'b0;
        chk("door_hold20", dopen, 1);
        run_to(25);
        chk("door_open25", dopen, 1);
        step();
        chk("door_open26", dopen, 0);
        chk("door_width", opencnt, 16);
        req = 8'h04;
        step();
        req = '0;
        chk("door_pend27", pending, 8'h04);
        step();
        chk("close_open28", dopen, 1);
        chk("close_pend28", pending, 0);
        inclose = 1'b1;
        step();
        inclose = 1'b0;
        chk("close_open29", dopen, 0);
        chk("close_close29", dclose, 1);
        inopen = 1'b1;
        inclose = 1'b1;
        step();
        chk("both_open30", dopen, 1);
        step();
        chk("both_open31", dopen, 1);
        step();
        inopen = 1'b0;
        inclose = 1'b0;
        chk("both_open32", dopen, 1);
        run_to(37);
        chk("both_open37", dopen, 1);
        step();
        chk("both_open38", dopen, 0);

        // call at the current floor
        do_reset();
        req = 8'h01;
        step();
        req = '0;
        chk("here_pend1", pending, 8'h01);
        step();
        chk("here_open2", dopen, 1);
        chk("here_pend2", pending, 0);
        run_to(9);
        chk("here_noup", upcnt, 0);
        chk("here_idle9", idle, 1);

        // reset in the middle of a trip
        do_reset();
        req = 8'h80;
        step();
        req = '0;
        run_to(19);
        chk("mrst_f19", floor, 4);
        chk("mrst_pend19", pending, 8'h80);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_floor", floor, 0);
        chk("mrst_pend", pending, 0);
        chk("mrst_up", up, 0);
        chk("mrst_close", dclose, 1);
        chk("mrst_idle", idle, 1);

        // four-landing instance
        do_reset();
        req4 = 4'h8;
        step();
        req4 = '0;
        chk("f4_pend1", pending4, 4'h8);
        run_to(13);
        chk("f4_up13", up4, 1);
        step();
        chk("f4_floor14", floor4, 3);
        chk("f4_open14", dopen4, 1);
        chk("f4_up14", up4, 0);
        chk("f4_upcnt", upcnt4, 12);
        run_to(16);
        req4 = 4'h8;
        step();
        req4 = '0;
        chk("f4_pend17", pending4, 0);
        chk("f4_open17", dopen4, 1);
        run_to(22);
        chk("f4_open22", dopen4, 1);
        step();
        chk("f4_open23", dopen4, 0);
        chk("f4_idle23", idle4, 1);
        chk("f4_maxfloor", maxf4, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/elevator_ctrl_scan.md
# elevator_ctrl_scan

Parametrised elevator car controller for FLOORS landings with a SCAN (directional) scheduler. It latches floor-call requests into a pending vector and serves them in the current direction of travel before reversing. It times per-floor travel and door dwell with internal counters and drives the car motor (up/down) and door (open/close) outputs. It replaces the fixed 8-input, untimed controller and sits between the floor/cabin button logic and the motor/door drivers.

## Interface
- FLOORS, 8, number of landings (>=2); floor 0 is ground
- TRAVEL_CYC, 4, clock cycles to move one floor (>=1)
- DOOR_CYC, 6, clock cycles the door stays open per stop (>=1)
- FW, $clog2(FLOORS), width of floor index (derived, not overridden)
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req  input  FLOORS  floor-call requests, one bit per landing, sampled every cycle (pulse or level)
- inopen  input  1  door-open button, held = extend dwell
- inclose  input  1  door-close button
- up  output  1  motor up
- down  output  1  motor down
- open  output  1  door open
- close  output  1  door closed
- floor  output  FW  present floor
- pending  output  FLOORS  latched, unserved requests
- idle  output  1  state IDLE and pending==0

## Operation
- All outputs registered. Reset values: up=0, down=0, open=0, close=1, floor=0, pending=0, idle=1; internal dir=UP, counters=0, state IDLE.
- Request latch: pending <= pending | req each cycle, except that the bit for the current floor is cleared on entry to OPEN and while in OPEN (a current-floor request during OPEN restarts the dwell counter instead).
- States: IDLE, MOVE, OPEN. Exactly one of open/close is 1. close=1 in IDLE and MOVE. up/down are nonzero only in MOVE, never both.
- IDLE uses the registered pending:
  - pending[floor] or inopen -> OPEN.
  - else if there are requests ahead in dir -> MOVE in dir.
  - else if there are requests behind -> reverse dir, MOVE.
  - else stay.
- MOVE: travel counter counts 0..TRAVEL_CYC-1. On the last count, floor +/-1 and the counter reloads. Then:
  - pending[new floor] -> OPEN.
  - else if there are requests beyond in dir -> stay in MOVE.
  - else -> IDLE.
  - Door buttons are ignored in MOVE.
- OPEN: dwell counter counts 0..DOOR_CYC-1, then -> IDLE.
  - inopen reloads the counter to 0.
  - inclose forces exit at the end of the current cycle.
  - If both are asserted, inopen wins.
- floor saturates at 0 and FLOORS-1; the scheduler never drives past either end.
- Mid-operation rst: the next cycle shows reset values. pending is discarded and floor=0 (the car is re-homed externally).

## Timing
- A req at cycle 0 is visible in pending at cycle 1. IDLE decides in cycle 1, and MOVE/OPEN outputs appear in cycle 2.
- A trip of d floors asserts up/down for exactly d*TRAVEL_CYC consecutive cycles. floor updates, open rises and the pending bit clears in the same cycle.
- open lasts DOOR_CYC cycles without buttons. With inclose asserted in the first open cycle, open lasts 1 cycle.
- Reversal costs one IDLE cycle at floors where the car stopped. A pass-through floor with no request adds no extra cycles.

## Test plan
- Reset: hold rst 2 cycles -> up=down=open=0, close=1, floor=0, pending=0, idle=1.
- Single trip (defaults): car idle at 0, req[5] pulsed at cycle 0:
  - pending=8'h20 at cycle 1.
  - up=1 cycles 2..21.
  - floor=5, open=1, pending=0 cycles 22..27.
  - close=1, idle=1 at cycle 28.
- SCAN order: car moving up at floor 3 toward 6, pulse req[1] and req[5] -> stops at 5, then 6 (open 6 cycles each), then reverses down to 1. down is never asserted before the floor-6 stop completes.
- Door buttons at a stop:
  - inopen held 10 cycles -> open stays 1 until DOOR_CYC cycles after release.
  - inclose on the first open cycle -> open width 1.
  - inopen and inclose together -> treated as inopen.
- Current-floor request and reset:
  - Idle at 0, req[0] at cycle 0 -> open=1 at cycle 2, up never asserted.
  - rst asserted during MOVE at floor 4 -> next cycle floor=0, pending=0, up=0, close=1.
- FLOORS=4, FW=2: from 0, req[3] -> up for 12 cycles, floor=3.
  - Further req[3] during OPEN restarts dwell, pending stays 0.
  - floor never exceeds 3.
